// File: rtl/mcu_io_pkg.sv
// mcu_io_pkg: register offsets and timing constants shared by mini-mcu I/O peripherals
package mcu_io_pkg;
    localparam logic [7:0] KEYPORT_LIVE_OFS = 8'd0;
    localparam logic [7:0] KEYPORT_FLAG_OFS = 8'd1;
    localparam logic [7:0] KEYPORT_MASK_OFS = 8'd2;
    localparam int DEBOUNCE_12MHZ_20MS = 240000;
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: 2-flop synchroniser plus stability counter for one asynchronous input bit
module debounce_cell #(
    parameter int   CYCLES = 4,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic sync,
    output logic stable
);
    localparam int W = $clog2(CYCLES);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);
    logic meta_q, sync_q, stable_q, stable_d;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d    = (sync_q == stable_q || cnt_q == LAST) ? '0 : cnt_q + W'(1);
        stable_d = (sync_q != stable_q && cnt_q == LAST) ? sync_q : stable_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q   <= INIT;
            sync_q   <= INIT;
            stable_q <= INIT;
            cnt_q    <= '0;
        end else begin
            meta_q   <= d;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
    assign sync   = sync_q;
    assign stable = stable_q;
endmodule

// File: rtl/mcu_key_port.sv
// mcu_key_port: debounced keys/switches, sticky clear-on-read press flags and maskable irq on the MCU port bus
// Define KEY_PORT_SW_DEBOUNCE_EN to debounce the switches as well as the keys.
module mcu_key_port
    import mcu_io_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = DEBOUNCE_12MHZ_20MS,
    parameter logic [7:0] BASE_PORT       = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    input  logic [3:0] sw,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       irq
);
    localparam logic [7:0] ADDR_LIVE = BASE_PORT + KEYPORT_LIVE_OFS;
    localparam logic [7:0] ADDR_FLAG = BASE_PORT + KEYPORT_FLAG_OFS;
    localparam logic [7:0] ADDR_MASK = BASE_PORT + KEYPORT_MASK_OFS;
    logic [3:0] key_sync, key_stable, sw_stable;
    logic [3:0] armed_q, armed_d, key_prev_q, key_prev_d, flag_q, flag_d, mask_q, mask_d;
    logic [1:0] settle_q, settle_d;
    logic       irq_q, irq_d, rd_flag, wr_mask;
    logic       unused_bits;
    for (genvar i = 0; i < 4; i++) begin : g_key
        debounce_cell #(.CYCLES(DEBOUNCE_CYCLES), .INIT(1'b1)) u_key (
            .clk(clk), .rst(rst), .d(key[i]), .sync(key_sync[i]), .stable(key_stable[i])
        );
    end
`ifdef KEY_PORT_SW_DEBOUNCE_EN
    logic [3:0] sw_sync_unused;
    for (genvar i = 0; i < 4; i++) begin : g_sw
        debounce_cell #(.CYCLES(DEBOUNCE_CYCLES), .INIT(1'b0)) u_sw (
            .clk(clk), .rst(rst), .d(sw[i]), .sync(sw_sync_unused[i]), .stable(sw_stable[i])
        );
    end
`else
    logic [3:0] sw_meta_q, sw_sync_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end
    assign sw_stable = sw_sync_q;
`endif
    // A key only arms once it has been seen released after reset, so a key held through reset raises no event.
    always_comb begin
        rd_flag    = read_strobe && port_id == ADDR_FLAG;
        wr_mask    = write_strobe && port_id == ADDR_MASK;
        settle_d   = {settle_q[0], 1'b1};
        armed_d    = armed_q | (settle_q[1] ? key_sync : 4'h0);
        key_prev_d = key_stable;
        flag_d     = (rd_flag ? 4'h0 : flag_q) | (armed_q & key_prev_q & ~key_stable);
        mask_d     = wr_mask ? out_port[3:0] : mask_q;
        irq_d      = |(flag_q & mask_q);
        in_port    = port_id == ADDR_LIVE ? {key_stable, sw_stable} :
                     port_id == ADDR_FLAG ? {4'h0, flag_q} :
                     port_id == ADDR_MASK ? {4'h0, mask_q} : 8'h00;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q   <= '0;
            armed_q    <= '0;
            key_prev_q <= 4'hF;
            flag_q     <= '0;
            mask_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            settle_q   <= settle_d;
            armed_q    <= armed_d;
            key_prev_q <= key_prev_d;
            flag_q     <= flag_d;
            mask_q     <= mask_d;
            irq_q      <= irq_d;
        end
    end
    assign irq         = irq_q;
    assign unused_bits = ^out_port[7:4];
endmodule

// File: tb/tb_mcu_key_port.sv
// tb_mcu_key_port: scoreboard bench for mcu_key_port with DEBOUNCE_CYCLES=4 and BASE_PORT=0
module tb_mcu_key_port;
`ifdef KEY_PORT_SW_DEBOUNCE_EN
    localparam int SW_LAT = 6;
`else
    localparam int SW_LAT = 2;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = 4'hF;
    logic [3:0] sw = 4'h0;
    logic [7:0] port_id = 8'h00;
    logic       read_strobe = 1'b0;
    logic       write_strobe = 1'b0;
    logic [7:0] out_port = 8'h00;
    logic [7:0] in_port;
    logic       irq;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] exp_q[$];
    string      name_q[$];
    logic [8:0] mon_e, mon_act;
    string      mon_n;

    mcu_key_port #(.DEBOUNCE_CYCLES(4), .BASE_PORT(8'h00)) dut (
        .clk(clk), .rst(rst), .key(key), .sw(sw), .port_id(port_id),
        .read_strobe(read_strobe), .write_strobe(write_strobe), .out_port(out_port),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    // bit 8 of an entry selects irq (1) or in_port (0) as the observed output
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_n   = name_q.pop_front();
            mon_act = mon_e[8] ? {1'b1, 7'b0, irq} : {1'b0, in_port};
            n_cmp++;
            if (mon_act !== mon_e) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", mon_n, mon_act[7:0], mon_e[7:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [7:0] p, input string n, input logic [7:0] e);
        port_id = p;
        exp_q.push_back({1'b0, e});
        name_q.push_back(n);
    endtask

    task automatic look_irq(input string n, input logic e);
        exp_q.push_back({1'b1, 7'b0, e});
        name_q.push_back(n);
    endtask

    initial begin
        repeat (3) tick();
        look(8'h00, "rst_live", 8'hF0);
        look_irq("rst_irq", 1'b0);
        rst = 1'b0;
        tick();
        look(8'h00, "idle_live", 8'hF0);
        look_irq("idle_irq", 1'b0);
        tick();
        look(8'h01, "idle_flag", 8'h00);
        tick();
        look(8'h02, "idle_mask", 8'h00);
        repeat (3) tick();

        key[2] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            look(8'h00, k < 6 ? "k2_wait" : "k2_stable", k < 6 ? 8'hF0 : 8'hB0);
        end
        tick();
        look(8'h01, "k2_flag", 8'h04);
        look_irq("k2_irq_masked", 1'b0);
        tick();
        look_irq("k2_irq_masked2", 1'b0);
        key[2] = 1'b1;
        repeat (8) tick();
        look(8'h01, "k2_release_noset", 8'h04);
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        look(8'h01, "k2_cleared", 8'h00);
        tick();

        key[0] = 1'b0;
        repeat (3) tick();
        key[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            look(8'h00, "glitch_live", 8'hF0);
        end
        tick();
        look(8'h01, "glitch_flag", 8'h00);

        tick();
        port_id = 8'h02;
        out_port = 8'h0F;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        look(8'h02, "mask_wr", 8'h0F);
        key[1] = 1'b0;
        repeat (6) tick();
        look(8'h00, "k1_stable", 8'hD0);
        tick();
        look(8'h01, "k1_flag", 8'h02);
        look_irq("k1_irq_lag", 1'b0);
        tick();
        look_irq("k1_irq", 1'b1);
        read_strobe = 1'b1;
        look(8'h01, "k1_read", 8'h02);
        tick();
        read_strobe = 1'b0;
        look(8'h01, "k1_cleared", 8'h00);
        look_irq("k1_irq_hold", 1'b1);
        tick();
        look_irq("k1_irq_drop", 1'b0);
        key[1] = 1'b1;
        repeat (8) tick();
        look(8'h01, "k1_release", 8'h00);
        look_irq("k1_release_irq", 1'b0);

        key[0] = 1'b0;
        repeat (8) tick();
        look(8'h01, "k0_flag", 8'h01);
        look_irq("k0_irq", 1'b1);
        key[3] = 1'b0;
        repeat (6) tick();
        read_strobe = 1'b1;
        look(8'h01, "race_read", 8'h01);
        tick();
        read_strobe = 1'b0;
        look(8'h01, "race_set_wins", 8'h08);
        look_irq("race_irq", 1'b1);
        tick();
        look_irq("race_irq2", 1'b1);
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        key = 4'hF;
        repeat (8) tick();
        look(8'h01, "race_cleanup", 8'h00);
        look_irq("race_cleanup_irq", 1'b0);
        tick();

        sw = 4'hA;
        for (int k = 1; k <= SW_LAT; k++) begin
            tick();
            look(8'h00, k < SW_LAT ? "sw_wait" : "sw_stable", k < SW_LAT ? 8'hF0 : 8'hFA);
        end
        tick();
        look(8'h07, "unmapped_07", 8'h00);
        tick();
        look(8'h03, "unmapped_03", 8'h00);
        tick();

        key[1] = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        look(8'h00, "held_live", 8'hDA);
        tick();
        look(8'h01, "held_noflag", 8'h00);
        key[1] = 1'b1;
        repeat (8) tick();
        look(8'h01, "held_release", 8'h00);
        key[1] = 1'b0;
        repeat (7) tick();
        look(8'h01, "held_repress", 8'h02);
        tick();
        tick();
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
